cond_sync: RTL

Input-conditioning stage directly upstream of the condition multiplexer in the microprogrammed controller. It brings the raw asynchronous condition inputs (switch and sensor lines such as `m`, `sl`, `sg`, `ls` and `lc`) into the `ck` domain through a synchroniser. It then debounces them on the slow strobe produced by the clock divider, and presents clean levels plus one-cycle edge pulses. Because of this, the microsequencer branches only on stable condition values.

---
 rtl/cond_pkg.sv | 13 +
 rtl/cond_bit.sv | 100 ++++++++++
 rtl/cond_sync.sv | 38 +++
 3 files changed

// File: rtl/cond_pkg.sv
// cond_pkg: shared defaults and helpers for the condition-input conditioning block.
package cond_pkg;

   // Default channel count and debounce depth.
   localparam int COND_N_DEF  = 5;
   localparam int COND_DB_DEF = 4;

   // Debounce counter width: enough bits to count 0..db-1, never less than one bit.
   function automatic int cond_cnt_w(input int db);
      return (db <= 2) ? 1 : $clog2(db);
   endfunction

endpackage

// File: rtl/cond_bit.sv
// cond_bit: one condition channel.
// The channel has a two-flop synchroniser, a tick-qualified debounce counter,
// registered rise/fall pulses, and an optional sticky rise flag.
// The sticky flag is enabled by defining COND_SYNC_LATCH_EN.
import cond_pkg::*;

module cond_bit #(
   parameter int DB_CYCLES = COND_DB_DEF
) (
   input  logic ck,
   input  logic rst,
   input  logic tick,
   input  logic i_raw,
   input  logic i_clr,
   output logic o_cond,
   output logic o_rise,
   output logic o_fall,
   output logic o_evt
);

   localparam int            CW       = cond_cnt_w(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          r_sync1;
   logic          r_s;
   logic [CW-1:0] r_cnt;
   logic          r_cond;
   logic          r_rise;
   logic          r_fall;
   logic          w_accept;

   // A new level is accepted on the tick that completes DB_CYCLES disagreeing samples.
   assign w_accept = tick && (r_s != r_cond) && (r_cnt == CNT_LAST);

   // Two-flop synchroniser bringing the asynchronous line into the ck domain.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_s     <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_s     <= r_sync1;
      end
   end

   // Debounce: count consecutive disagreeing ticks; any agreeing tick restarts the count.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_cond <= 1'b0;
      end else if (tick) begin
         if (r_s == r_cond) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_cond <= r_s;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   // Edge pulses rise with the accepted level change and drop one cycle later.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_accept &  r_s;
         r_fall <= w_accept & ~r_s;
      end
   end

   assign o_cond = r_cond;
   assign o_rise = r_rise;
   assign o_fall = r_fall;

`ifdef COND_SYNC_LATCH_EN
   logic r_evt;

   // Sticky rise flag so a slow microprogram can still see a pulse it missed; set beats clear.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         r_evt <= 1'b0;
      end else if (w_accept && r_s) begin
         r_evt <= 1'b1;
      end else if (i_clr) begin
         r_evt <= 1'b0;
      end
   end

   assign o_evt = r_evt;
`else
   logic w_unused_clr;

   assign w_unused_clr = i_clr;
   assign o_evt        = 1'b0;
`endif

endmodule

// File: rtl/cond_sync.sv
// cond_sync: synchronise, debounce and edge-detect the raw condition inputs.
// The outputs feed the condition multiplexer.
// Define COND_SYNC_LATCH_EN to enable the sticky evt flags and their clr inputs.
import cond_pkg::*;

module cond_sync #(
   parameter int N         = COND_N_DEF,
   parameter int DB_CYCLES = COND_DB_DEF
) (
   input  logic         ck,
   input  logic         rst,
   input  logic         tick,
   input  logic [N-1:0] raw,
   output logic [N-1:0] cond,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall,
   input  logic [N-1:0] clr,
   output logic [N-1:0] evt
);

   // Channels are fully independent; one conditioning slice per input line.
   for (genvar g = 0; g < N; g++) begin : g_ch
      cond_bit #(
         .DB_CYCLES (DB_CYCLES)
      ) u_bit (
         .ck     (ck),
         .rst    (rst),
         .tick   (tick),
         .i_raw  (raw[g]),
         .i_clr  (clr[g]),
         .o_cond (cond[g]),
         .o_rise (rise[g]),
         .o_fall (fall[g]),
         .o_evt  (evt[g])
      );
   end

endmodule
